// File: rtl/pipe_mux_nto1.sv
// N:1 registered selector with valid/ready handshake, 2-entry skid buffer and flush.
// Optional PIPE_MUX_SEL_CHECK_EN adds a sticky sel_err flag and an output-stability assertion.
module pipe_mux_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef PIPE_MUX_SEL_CHECK_EN
    ,
    output logic                    sel_err
`endif
);

    // State encodes {out_valid, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  skid_d;
    logic [SEL_W-1:0]  skid_s;
    logic [WIDTH-1:0]  sel_word;
    logic              accept;
    logic              release_o;
    logic              load_main;
    logic              load_skid;
    logic              skid_to_main;

    assign out_valid = state[1];
    assign accept    = in_valid & in_ready;
    assign release_o = out_valid & out_ready;

    // Out-of-range selects match no input and yield zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_n      = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && release_o) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_n   = FULL;
                        load_skid = 1'b1;
                    end else if (release_o) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (release_o) begin
                        state_n      = ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            in_ready <= ~state_n[0];
        end
    end

    // Data registers are left untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
            skid_d   <= '0;
            skid_s   <= '0;
        end else begin
            if (load_main) begin
                out_data <= sel_word;
                out_sel  <= sel;
            end else if (skid_to_main) begin
                out_data <= skid_d;
                out_sel  <= skid_s;
            end
            if (load_skid) begin
                skid_d <= sel_word;
                skid_s <= sel;
            end
        end
    end

`ifdef PIPE_MUX_SEL_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && (int'(sel) >= NUM_IN)) begin
            sel_err <= 1'b1;
        end
    end

    a_out_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel))
    );
`endif

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Scoreboard testbench for pipe_mux_nto1 (NUM_IN=4 main instance, NUM_IN=3 range instance).
module tb_pipe_mux_nto1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [127:0] in_data = {32'h33, 32'h22, 32'h11, 32'h00};
    logic [1:0]  sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic        f3 = 1'b0;
    logic [95:0] d3 = {32'h22, 32'h11, 32'h00};
    logic [1:0]  s3 = '0;
    logic        v3 = 1'b0;
    logic        ir3;
    logic [31:0] od3;
    logic [1:0]  os3;
    logic        ov3;
    logic        r3 = 1'b0;
`ifdef PIPE_MUX_SEL_CHECK_EN
    logic        sel_err;
    logic        sel_err3;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    pipe_mux_nto1 #(.WIDTH(32), .NUM_IN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
        .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    pipe_mux_nto1 #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(f3), .in_data(d3),
        .sel(s3), .in_valid(v3), .in_ready(ir3),
        .out_data(od3), .out_sel(os3), .out_valid(ov3),
        .out_ready(r3)
`ifdef PIPE_MUX_SEL_CHECK_EN
        , .sel_err(sel_err3)
`endif
    );

    // Reference words for the 4-input instance: word k = 0x11 * k.
    function automatic logic [31:0] exp_word(input logic [1:0] s);
        return 32'h11 * 32'(s);
    endfunction

    // Releases are seen at negedge; flush squashes whatever is in flight.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got sel=%0d data=%h, expected nothing", out_sel, out_data);
            end else begin
                logic [33:0] e;
                e = q.pop_front();
                if ({out_sel, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got sel=%0d data=%h, expected sel=%0d data=%h",
                             out_sel, out_data, e[33:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        out_ready = r;
        flush     = f;
        if (f) q.delete();
        else if (v && in_ready) q.push_back({s, exp_word(s)});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            drive(1'b0, 2'd0, 1'b1, 1'b0);
            n++;
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, in_ready, out_data, out_sel} !== {1'b0, 1'b1, 32'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset: got v=%b rdy=%b d=%h s=%0d, expected v=0 rdy=1 d=0 s=0",
                     out_valid, in_ready, out_data, out_sel);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, 32'h22, 2'd2}) begin
            n_fail++;
            $display("FAIL single: got v=%b d=%h s=%0d, expected v=1 d=22 s=2",
                     out_valid, out_data, out_sel);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got v=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 1'b1, 1'b0);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready: i=%0d got %b, expected 1", i, in_ready);
            end
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h33}) begin
            n_fail++;
            $display("FAIL b2b_last: got v=%b d=%h, expected v=1 d=33", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_data, in_ready} !== {1'b1, 32'h11, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_one: got v=%b d=%h rdy=%b, expected v=1 d=11 rdy=1",
                     out_valid, out_data, in_ready);
        end
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if ({out_data, in_ready} !== {32'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_full: got d=%h rdy=%b, expected d=11 rdy=0", out_data, in_ready);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, 32'h11, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b d=%h s=%0d, expected v=1 d=11 s=1",
                     out_valid, out_data, out_sel);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if ({out_data, in_ready} !== {32'h33, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_release: got d=%h rdy=%b, expected d=33 rdy=1", out_data, in_ready);
        end
        drain();
    endtask

    task automatic test_out_of_range();
        @(posedge clk);
        #1;
        v3 = 1'b1;
        s3 = 2'd3;
        r3 = 1'b0;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        n_checks++;
        if ({ov3, od3, os3} !== {1'b1, 32'h0, 2'd3}) begin
            n_fail++;
            $display("FAIL oor: got v=%b d=%h s=%0d, expected v=1 d=0 s=3", ov3, od3, os3);
        end
`ifdef PIPE_MUX_SEL_CHECK_EN
        n_checks++;
        if (sel_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_err: got %b, expected 1", sel_err3);
        end
`endif
        f3 = 1'b1;
        @(posedge clk);
        #1;
        f3 = 1'b0;
        n_checks++;
        if ({ov3, ir3, od3, os3} !== {1'b0, 1'b1, 32'h0, 2'd3}) begin
            n_fail++;
            $display("FAIL oor_flush: got v=%b rdy=%b d=%h s=%0d, expected v=0 rdy=1 d=0 s=3",
                     ov3, ir3, od3, os3);
        end
`ifdef PIPE_MUX_SEL_CHECK_EN
        n_checks++;
        if (sel_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_sticky: got %b, expected 1", sel_err3);
        end
`endif
    endtask

    task automatic test_flush_full();
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if ({out_valid, in_ready, out_data, out_sel} !== {1'b0, 1'b1, 32'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL flush: got v=%b rdy=%b d=%h s=%0d, expected v=0 rdy=1 d=0 s=0",
                     out_valid, in_ready, out_data, out_sel);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_quiet: got v=%b, expected 0", out_valid);
        end
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_full: got rdy=%b, expected 0", in_ready);
        end
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_data, out_sel} !== {1'b0, 1'b1, 32'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b rdy=%b d=%h s=%0d, expected v=0 rdy=1 d=0 s=0",
                     out_valid, in_ready, out_data, out_sel);
        end
        #3;
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        n_checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, 32'h33, 2'd3}) begin
            n_fail++;
            $display("FAIL ar_first: got v=%b d=%h s=%0d, expected v=1 d=33 s=3",
                     out_valid, out_data, out_sel);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_flush_full();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_mux_nto1.md
Name: pipe_mux_nto1

Overview:
- Parametrised N:1 selector with one pipeline register stage and a valid/ready handshake.
- Replaces ad-hoc combinational 4:1 selects on datapath paths that need a register stage. Examples: writeback source select, PC-source select feeding fetch.
- Holds a 2-entry skid buffer, so the upstream stage always sees a registered ready.
- Has a synchronous flush for pipeline squash on branch or jump.

Parameters:
- WIDTH, 32, bit width of each data input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled only on an accepted transfer.
- in_valid  in  1  upstream has data.
- in_ready  out  1  block can accept; driven directly by a flop.
- out_data  out  WIDTH  selected data from the output register.
- out_sel  out  SEL_W  index that produced out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - out_data = 0, out_sel = 0, out_valid = 0.
  - Skid entry empty, in_ready = 1.
- Accept / release conditions:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
- Selection:
  - On accept, the word captured is in_data[sel*WIDTH +: WIDTH], together with sel.
  - If sel >= NUM_IN (NUM_IN not a power of 2), the captured word is 0 and the captured out_sel is the raw sel.
- Latency: 1 cycle from accept to out_valid when the output register is free.
- Storage:
  - Main register drives the outputs.
  - Skid register (skid_v, skid_d, skid_s) holds one extra entry.
  - in_ready is registered as !skid_v_next.
- Transitions by {out_valid, skid_v} (EMPTY = 00, ONE = 10, FULL = 11; state 01 is illegal):
  - EMPTY + accept -> ONE; main loads.
  - ONE + accept + release -> ONE; main loads the new word, no bubble.
  - ONE + accept + no release -> FULL; skid loads; in_ready = 0 next cycle.
  - ONE + release + no accept -> EMPTY.
  - FULL + release -> ONE; skid moves into main; in_ready = 1 next cycle.
  - FULL + no release -> FULL; all held stable.
- Accept cannot occur in FULL, because in_ready = 0.
- Output stability: out_data and out_sel must not change while out_valid & !out_ready.
- Flush:
  - flush = 1 at an edge clears out_valid and skid_v and sets in_ready = 1. Any same-cycle accept is dropped.
  - out_data and out_sel keep their last values.
  - flush has priority over accept and release.
- Reset asserted mid-operation: immediate return to the reset values, independent of clk. The first accept is allowed on the first edge after deassertion.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PIPE_MUX_SEL_CHECK_EN.
- Defined:
  - Adds output sel_err (1 bit, reset 0), a sticky flag.
  - sel_err is set on any accept with sel >= NUM_IN.
  - Cleared only by rst_n; flush does not clear it.
  - Adds a simulation-only assertion that out_data stays stable under backpressure.
- Undefined:
  - Port and logic are absent.
  - Out-of-range sel still yields 0 data.

Test Plan:
- Reset then single transfer: NUM_IN=4, WIDTH=32; in_data = {D3..D0} = {0x33,0x22,0x11,0x00}, sel=2, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x22, out_sel=2; following cycle out_valid=0.
- Back-to-back streaming: sel cycles 0,1,2,3 on consecutive cycles, out_ready=1 -> outputs 0x00,0x11,0x22,0x33 on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0 while sending sel=1 then sel=3 -> out_data holds 0x11, in_ready drops after the 2nd accept; raise out_ready -> 0x11 then 0x33 released; in_ready returns to 1.
- Out-of-range select: NUM_IN=3, sel=3, in_valid=1 -> out_data=0, out_sel=3; with PIPE_MUX_SEL_CHECK_EN, sel_err=1 and stays 1 after flush.
- Flush in FULL state: fill both entries with out_ready=0, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no data emitted afterwards.
- Async reset mid-stream: drop rst_n between clock edges while in FULL -> out_valid=0 and in_ready=1 immediately, with no clock edge needed.
